mp_product_accumulator: RTL and testbench
=========================================

// Module: mp_product_accumulator
// PURPOSE
//   Downstream stage of the mixed-precision multiplier. Accumulates a stream of
//   64-bit signed Q32.32 products over a programmable vector length (dot-product
//   reduction), then rounds and saturates the sum to a 32-bit signed integer.
//   Valid/ready on both sides; feeds the activation/writeback stage of the AI path.
// PARAMETERS
//   IN_W       64            product width (signed, FRAC_SHIFT fraction bits)
//   LEN_W      8             vector-length field width; max length 2^LEN_W-1
//   ACC_W      IN_W+LEN_W    accumulator width; guarantees no internal overflow
//   OUT_W      32            result width (signed)
//   FRAC_SHIFT 32            fraction bits dropped at rounding
// PORTS
//   clk        in   1      clock, all logic on rising edge
//   rst_n      in   1      reset, synchronous, active-low
//   start      in   1      begin new reduction; honoured only in IDLE
//   vec_len    in   LEN_W  number of products to accumulate, sampled with start
//   prod_valid in   1      product available
//   prod_ready out  1      block accepts product this cycle
//   prod_data  in   IN_W   signed product
//   res_valid  out  1      result available
//   res_ready  in   1      consumer accepts result
//   res_data   out  OUT_W  rounded, saturated signed result
//   res_sat    out  1      result was clipped (valid with res_valid)
//   busy       out  1      state != IDLE
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state=IDLE, acc=0, cnt=0; prod_ready, res_valid,
//   res_data, res_sat, busy all 0. Reset mid-operation abandons the reduction;
//   partial sum discarded, no result produced.
// - FSM: IDLE -> ACCUM -> ROUND -> OUT -> IDLE.
// - IDLE: prod_ready=0. start=1: latch vec_len into cnt, clear acc.
//   vec_len!=0 -> ACCUM; vec_len==0 -> OUT with res_data=0, res_sat=0.
// - ACCUM: prod_ready=1. Transfer when prod_valid&&prod_ready:
//   acc <= acc + sign_ext(prod_data), cnt <= cnt-1. Transfer with cnt==1 -> ROUND.
//   No transfer: hold acc and cnt (gaps in prod_valid allowed).
// - ROUND (1 cycle, prod_ready=0): r = (acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT,
//   arithmetic shift at ACC_W. Ties round toward +inf (+0.5 -> 1, -0.5 -> 0).
//   Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; register into res_data;
//   res_sat=1 iff clamped. -> OUT.
// - OUT: res_valid=1; res_data/res_sat stable until res_valid&&res_ready,
//   then res_valid=0 next cycle, -> IDLE.
// - start outside IDLE ignored, never queued. A start in the same cycle as the
//   OUT handshake is also ignored; start is taken earliest the next cycle.
// - Latency: start sampled cycle T, ACCUM from T+1. Last transfer at cycle N:
//   ROUND at N+1, res_valid=1 at N+2. vec_len=0: res_valid=1 at T+1.
// - Throughput: one product per cycle in ACCUM; a new reduction starts earliest
//   one cycle after the OUT handshake.
// - prod_data is ignored outside ACCUM; prod_ready=0 there, so no transfer occurs.
// TESTING
// 1. vec_len=3, prod=1<<32, 2<<32, 3<<32 back-to-back, res_ready=1
//    -> res_data=6, res_sat=0, res_valid exactly 2 cycles after the 3rd transfer.
// 2. Rounding, vec_len=1: 0x0000_0000_8000_0000 -> 1;
//    0xFFFF_FFFF_8000_0000 -> 0; 0xFFFF_FFFF_7FFF_FFFF -> -1 (0xFFFF_FFFF).
// 3. Saturation, vec_len=2, 0x7FFF_FFFF_0000_0000 twice -> 0x7FFF_FFFF, res_sat=1;
//    0x8000_0000_0000_0000 twice -> 0x8000_0000, res_sat=1.
// 4. vec_len=0 -> res_valid=1 one cycle after start, res_data=0, no prod_ready pulse.
// 5. Backpressure: random prod_valid gaps; res_ready low 5 cycles with start pulsed
//    during OUT -> res_data stable, start ignored, single result per reduction.
// 6. rst_n=0 for 1 cycle mid-ACCUM (2 of 4 products sent) -> all outputs 0 next
//    cycle, IDLE; then vec_len=1, prod=5<<32 -> res_data=5.

Source files
------------

// File: rtl/mp_product_accumulator_if.sv
// Handshake bundle between the multiplier's product stream, the accumulator
// and the activation/writeback consumer.
interface mp_product_accumulator_if #(
   parameter int IN_W  = 64,
   parameter int LEN_W = 8,
   parameter int OUT_W = 32
);
   logic             start;
   logic [LEN_W-1:0] vec_len;
   logic             prod_valid;
   logic             prod_ready;
   logic [IN_W-1:0]  prod_data;
   logic             res_valid;
   logic             res_ready;
   logic [OUT_W-1:0] res_data;
   logic             res_sat;
   logic             busy;

   modport master (
      output start, vec_len, prod_valid, prod_data, res_ready,
      input  prod_ready, res_valid, res_data, res_sat, busy
   );

   modport slave (
      input  start, vec_len, prod_valid, prod_data, res_ready,
      output prod_ready, res_valid, res_data, res_sat, busy
   );
endinterface

// File: rtl/mp_product_accumulator.sv
// Dot-product reduction of signed Q32.32 products, followed by round-half-up
// and saturation to a signed OUT_W-bit integer.
module mp_product_accumulator #(
   parameter int IN_W       = 64,
   parameter int LEN_W      = 8,
   parameter int ACC_W      = IN_W + LEN_W,
   parameter int OUT_W      = 32,
   parameter int FRAC_SHIFT = 32
) (
   input logic                   clk,
   input logic                   rst_n,
   mp_product_accumulator_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUT} state_t;

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic             sat;
   } res_t;

   localparam logic signed [ACC_W-1:0] RND_BIAS =
      {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_SHIFT-1);
   localparam logic signed [ACC_W-1:0] OUT_MAX =
      {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OUT_MIN =
      {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   state_t                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   res_t                    res_q, res_d;

   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] rnd_sum;
   logic signed [ACC_W-1:0] rnd_val;

   assign prod_ext = {{(ACC_W-IN_W){bus.prod_data[IN_W-1]}}, bus.prod_data};
   // Bias then floor-shift gives ties toward +inf; ACC_W headroom absorbs the bias.
   assign rnd_sum  = acc_q + RND_BIAS;
   assign rnd_val  = rnd_sum >>> FRAC_SHIFT;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cnt_d = bus.vec_len;
               acc_d = '0;
               if (bus.vec_len == '0) begin
                  res_d   = '0;
                  state_d = OUT;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (bus.prod_valid) begin
               acc_d = acc_q + prod_ext;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == LEN_W'(1)) state_d = ROUND;
            end
         end
         ROUND: begin
            if (rnd_val > OUT_MAX) begin
               res_d.data = OUT_MAX[OUT_W-1:0];
               res_d.sat  = 1'b1;
            end else if (rnd_val < OUT_MIN) begin
               res_d.data = OUT_MIN[OUT_W-1:0];
               res_d.sat  = 1'b1;
            end else begin
               res_d.data = rnd_val[OUT_W-1:0];
               res_d.sat  = 1'b0;
            end
            state_d = OUT;
         end
         OUT: begin
            if (bus.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.prod_ready = (state_q == ACCUM);
   assign bus.res_valid  = (state_q == OUT);
   assign bus.busy       = (state_q != IDLE);
   assign bus.res_data   = res_q.data;
   assign bus.res_sat    = res_q.sat;

endmodule

// File: tb/tb_mp_product_accumulator.sv
// Directed vector bench for mp_product_accumulator: table of reductions plus
// hand-written backpressure, empty-vector and mid-reduction reset sequences.
module tb_mp_product_accumulator;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   mp_product_accumulator_if #(.IN_W(64), .LEN_W(8), .OUT_W(32)) bus ();

   mp_product_accumulator #(
      .IN_W(64), .LEN_W(8), .ACC_W(72), .OUT_W(32), .FRAC_SHIFT(32)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string           name;
      int              len;
      logic [3:0][63:0] prod;
      logic [31:0]     exp_data;
      logic            exp_sat;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      bus.res_ready = 1'b1;
      bus.start     = 1'b1;
      bus.vec_len   = 8'(v.len);
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < v.len; i++) begin
         bus.prod_valid = 1'b1;
         bus.prod_data  = v.prod[i];
         chk({v.name, "_prod_ready"}, 64'(bus.prod_ready), 64'd1);
         @(negedge clk);
      end
      bus.prod_valid = 1'b0;
      bus.prod_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      chk({v.name, "_round_no_valid"}, 64'(bus.res_valid), 64'd0);
      chk({v.name, "_round_no_ready"}, 64'(bus.prod_ready), 64'd0);
      @(negedge clk);
      chk({v.name, "_res_valid"}, 64'(bus.res_valid), 64'd1);
      chk({v.name, "_res_data"}, 64'(bus.res_data), 64'(v.exp_data));
      chk({v.name, "_res_sat"}, 64'(bus.res_sat), 64'(v.exp_sat));
      @(negedge clk);
      chk({v.name, "_done"}, {62'd0, bus.res_valid, bus.busy}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   sent;
      int   cyc;
      logic [3:0][63:0] bp_prod;

      checks   = 0;
      failures = 0;
      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.vec_len    = '0;
      bus.prod_valid = 1'b0;
      bus.prod_data  = '0;
      bus.res_ready  = 1'b1;

      vecs[0] = '{"acc3", 3, {64'd0, 64'h3_0000_0000, 64'h2_0000_0000, 64'h1_0000_0000}, 32'd6, 1'b0};
      vecs[1] = '{"rnd_pos_half", 1, {192'd0, 64'h0000_0000_8000_0000}, 32'd1, 1'b0};
      vecs[2] = '{"rnd_neg_half", 1, {192'd0, 64'hFFFF_FFFF_8000_0000}, 32'd0, 1'b0};
      vecs[3] = '{"rnd_below_neg_half", 1, {192'd0, 64'hFFFF_FFFF_7FFF_FFFF}, 32'hFFFF_FFFF, 1'b0};
      vecs[4] = '{"sat_pos", 2, {128'd0, 64'h7FFF_FFFF_0000_0000, 64'h7FFF_FFFF_0000_0000}, 32'h7FFF_FFFF, 1'b1};
      vecs[5] = '{"sat_neg", 2, {128'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000}, 32'h8000_0000, 1'b1};
      vecs[6] = '{"mixed_sign", 2, {128'd0, 64'hFFFF_FFFD_0000_0000, 64'h0000_0001_4000_0000}, 32'hFFFF_FFFE, 1'b0};
      vecs[7] = '{"quarters", 4, {64'h4000_0000, 64'h4000_0000, 64'h4000_0000, 64'h4000_0000}, 32'd1, 1'b0};
      vecs[8] = '{"edge_max", 1, {192'd0, 64'h7FFF_FFFF_7FFF_FFFF}, 32'h7FFF_FFFF, 1'b0};
      vecs[9] = '{"edge_over", 1, {192'd0, 64'h7FFF_FFFF_8000_0000}, 32'h7FFF_FFFF, 1'b1};

      repeat (2) @(negedge clk);
      chk("reset_outputs", {59'd0, bus.prod_ready, bus.res_valid, bus.res_sat, bus.busy, 1'b0},
          64'd0);
      chk("reset_res_data", 64'(bus.res_data), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Empty vector: straight to OUT with a zero result.
      @(negedge clk);
      bus.res_ready = 1'b0;
      bus.start     = 1'b1;
      bus.vec_len   = 8'd0;
      chk("len0_no_ready_idle", 64'(bus.prod_ready), 64'd0);
      @(negedge clk);
      bus.start = 1'b0;
      chk("len0_res_valid", 64'(bus.res_valid), 64'd1);
      chk("len0_res_data", 64'(bus.res_data), 64'd0);
      chk("len0_res_sat", 64'(bus.res_sat), 64'd0);
      chk("len0_no_ready", 64'(bus.prod_ready), 64'd0);
      bus.res_ready = 1'b1;
      @(negedge clk);
      chk("len0_done", {62'd0, bus.res_valid, bus.busy}, 64'd0);

      // Backpressure: gapped products, stalled result, start pulses during OUT.
      bp_prod = {64'h4_0000_0000, 64'h3_0000_0000, 64'h2_0000_0000, 64'h1_0000_0000};
      bus.start   = 1'b1;
      bus.vec_len = 8'd4;
      @(negedge clk);
      bus.start = 1'b0;
      sent = 0;
      cyc  = 0;
      while (sent < 4 && cyc < 100) begin
         bus.prod_valid = ($urandom_range(0, 2) != 0);
         bus.prod_data  = bp_prod[sent];
         if (bus.prod_valid && bus.prod_ready) sent++;
         cyc++;
         @(negedge clk);
      end
      bus.prod_valid = 1'b0;
      chk("bp_all_sent", 64'(sent), 64'd4);
      bus.res_ready = 1'b0;
      cyc = 0;
      while (!bus.res_valid && cyc < 10) begin
         cyc++;
         @(negedge clk);
      end
      chk("bp_res_valid_seen", 64'(bus.res_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_valid", 64'(bus.res_valid), 64'd1);
         chk("bp_hold_data", 64'(bus.res_data), 64'd10);
         bus.start   = (i == 2);
         bus.vec_len = 8'd1;
         @(negedge clk);
      end
      bus.start     = 1'b1;
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("bp_after_hs", {62'd0, bus.res_valid, bus.busy}, 64'd0);
      @(negedge clk);
      chk("bp_start_not_queued", 64'(bus.busy), 64'd0);

      // Reset in the middle of a 4-product reduction.
      bus.start   = 1'b1;
      bus.vec_len = 8'd4;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.prod_valid = 1'b1;
         bus.prod_data  = 64'h7_0000_0000;
         @(negedge clk);
      end
      bus.prod_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_mid_flags", {60'd0, bus.prod_ready, bus.res_valid, bus.res_sat, bus.busy}, 64'd0);
      chk("rst_mid_data", 64'(bus.res_data), 64'd0);
      repeat (3) @(negedge clk);
      chk("rst_mid_no_result", {62'd0, bus.res_valid, bus.busy}, 64'd0);
      run_vec('{"after_reset", 1, {192'd0, 64'h5_0000_0000}, 32'd5, 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
